// File: rtl/cfg_reader_pkg.sv
// ----------------------------------------------------------------------------
// cfg_reader_pkg
//
// Shared types and constants for the configuration read-back block.
//
// Contents:
//   - cache_type_t / cva6_cfg_t : the subset of the core configuration record
//     that the read-back table publishes. Field names match
//     config_pkg::cva6_cfg_t so a full config can be mapped field-for-field.
//   - cva6_cfg_empty            : all-zero configuration (default parameter).
//   - cfg_idx_e, CfgNumEntries  : table word order and length.
//   - IsaBit*                   : bit positions inside the ISA bitmap word.
//   - CfgMagic                  : frame header identifier (bits [31:16]).
//   - dump_state_e              : stream dump FSM states.
//
// Optional feature macro: CVA6_CFG_READER_CSUM_EN adds the DUMP_CSUM state.
// ----------------------------------------------------------------------------
package cfg_reader_pkg;

  typedef enum logic [2:0] {
    WB             = 3'd0,
    WT             = 3'd1,
    HPDCACHE_WT    = 3'd2,
    HPDCACHE_WB    = 3'd3,
    HPDCACHE_WT_WB = 3'd4
  } cache_type_t;

  typedef struct packed {
    logic [31:0] XLEN;
    logic [31:0] VLEN;
    logic [31:0] PLEN;
    logic [31:0] GPLEN;
    logic        RVA;
    logic        RVB;
    logic        RVC;
    logic        RVD;
    logic        RVF;
    logic        RVH;
    logic        RVV;
    logic        RVS;
    logic        RVU;
    logic        ZKN;
    logic        RVZCB;
    logic        RVZCMT;
    logic        RVZCMP;
    logic        RVZiCond;
    logic        RVZicntr;
    logic        RVZihpm;
    logic        RVZilsd;
    logic        XF16;
    logic        XF16ALT;
    logic        XF8;
    logic        XFVec;
    logic        CvxifEn;
    logic        MmuPresent;
    logic        SuperscalarEn;
    logic [31:0] NrCommitPorts;
    logic [31:0] NrIssuePorts;
    logic [31:0] NR_SB_ENTRIES;
    logic [31:0] NrWbPorts;
    logic [31:0] NrRgprPorts;
    logic [31:0] FLen;
    logic [31:0] ICACHE_SET_ASSOC;
    logic [31:0] ICACHE_INDEX_WIDTH;
    logic [31:0] ICACHE_LINE_WIDTH;
    logic [31:0] DCACHE_SET_ASSOC;
    logic [31:0] DCACHE_INDEX_WIDTH;
    logic [31:0] DCACHE_LINE_WIDTH;
    cache_type_t DCacheType;
    logic [31:0] InstrTlbEntries;
    logic [31:0] DataTlbEntries;
    logic [31:0] NrPMPEntries;
    logic [31:0] BTBEntries;
    logic [31:0] BHTEntries;
    logic [31:0] RASDepth;
    logic [31:0] FETCH_WIDTH;
    logic [31:0] AxiDataWidth;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  typedef enum logic [4:0] {
    CFG_XLEN               = 5'd0,
    CFG_VLEN               = 5'd1,
    CFG_PLEN               = 5'd2,
    CFG_GPLEN              = 5'd3,
    CFG_ISA                = 5'd4,
    CFG_NR_COMMIT_PORTS    = 5'd5,
    CFG_NR_ISSUE_PORTS     = 5'd6,
    CFG_NR_SB_ENTRIES      = 5'd7,
    CFG_NR_WB_PORTS        = 5'd8,
    CFG_NR_RGPR_PORTS      = 5'd9,
    CFG_FLEN               = 5'd10,
    CFG_ICACHE_SET_ASSOC   = 5'd11,
    CFG_ICACHE_INDEX_WIDTH = 5'd12,
    CFG_ICACHE_LINE_WIDTH  = 5'd13,
    CFG_DCACHE_SET_ASSOC   = 5'd14,
    CFG_DCACHE_INDEX_WIDTH = 5'd15,
    CFG_DCACHE_LINE_WIDTH  = 5'd16,
    CFG_DCACHE_TYPE        = 5'd17,
    CFG_INSTR_TLB_ENTRIES  = 5'd18,
    CFG_DATA_TLB_ENTRIES   = 5'd19,
    CFG_NR_PMP_ENTRIES     = 5'd20,
    CFG_BTB_ENTRIES        = 5'd21,
    CFG_BHT_ENTRIES        = 5'd22,
    CFG_RAS_DEPTH          = 5'd23,
    CFG_FETCH_WIDTH        = 5'd24,
    CFG_AXI_DATA_WIDTH     = 5'd25
  } cfg_idx_e;

  localparam int unsigned CfgNumEntries = 26;

  localparam int unsigned IsaBitRva           = 0;
  localparam int unsigned IsaBitRvb           = 1;
  localparam int unsigned IsaBitRvc           = 2;
  localparam int unsigned IsaBitRvd           = 3;
  localparam int unsigned IsaBitRvf           = 4;
  localparam int unsigned IsaBitRvh           = 5;
  localparam int unsigned IsaBitRvv           = 6;
  localparam int unsigned IsaBitRvs           = 7;
  localparam int unsigned IsaBitRvu           = 8;
  localparam int unsigned IsaBitZkn           = 9;
  localparam int unsigned IsaBitRvzcb         = 10;
  localparam int unsigned IsaBitRvzcmt        = 11;
  localparam int unsigned IsaBitRvzcmp        = 12;
  localparam int unsigned IsaBitRvzicond      = 13;
  localparam int unsigned IsaBitRvzicntr      = 14;
  localparam int unsigned IsaBitRvzihpm       = 15;
  localparam int unsigned IsaBitRvzilsd       = 16;
  localparam int unsigned IsaBitXf16          = 17;
  localparam int unsigned IsaBitXf16alt       = 18;
  localparam int unsigned IsaBitXf8           = 19;
  localparam int unsigned IsaBitXfvec         = 20;
  localparam int unsigned IsaBitCvxifEn       = 21;
  localparam int unsigned IsaBitMmuPresent    = 22;
  localparam int unsigned IsaBitSuperscalarEn = 23;

  localparam logic [15:0] CfgMagic = 16'hCF6A;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_HDR  = 2'd1,
    DUMP_BODY = 2'd2
`ifdef CVA6_CFG_READER_CSUM_EN
    , DUMP_CSUM = 2'd3
`endif
  } dump_state_e;

endpackage

// File: rtl/cva6_cfg_table.sv
// ----------------------------------------------------------------------------
// cva6_cfg_table
//
// Combinational index-to-word lookup of the published configuration table.
// Two independent read ports so the random-read path and the stream dump
// share one table without arbitration.
//
// Ports:
//   idx_a   in  6   port A index (may be out of range)
//   word_a  out 32  port A word, 0 when out of range
//   oor_a   out 1   port A index >= CfgNumEntries
//   idx_b   in  6   port B index
//   word_b  out 32  port B word, 0 when out of range
// ----------------------------------------------------------------------------
module cva6_cfg_table
  import cfg_reader_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
  input  logic [5:0]  idx_a,
  output logic [31:0] word_a,
  output logic        oor_a,
  input  logic [5:0]  idx_b,
  output logic [31:0] word_b
);

  logic [31:0] isa_map;
  logic [31:0] entry [CfgNumEntries];

  always_comb begin
    isa_map = '0;
    isa_map[IsaBitRva]           = CVA6Cfg.RVA;
    isa_map[IsaBitRvb]           = CVA6Cfg.RVB;
    isa_map[IsaBitRvc]           = CVA6Cfg.RVC;
    isa_map[IsaBitRvd]           = CVA6Cfg.RVD;
    isa_map[IsaBitRvf]           = CVA6Cfg.RVF;
    isa_map[IsaBitRvh]           = CVA6Cfg.RVH;
    isa_map[IsaBitRvv]           = CVA6Cfg.RVV;
    isa_map[IsaBitRvs]           = CVA6Cfg.RVS;
    isa_map[IsaBitRvu]           = CVA6Cfg.RVU;
    isa_map[IsaBitZkn]           = CVA6Cfg.ZKN;
    isa_map[IsaBitRvzcb]         = CVA6Cfg.RVZCB;
    isa_map[IsaBitRvzcmt]        = CVA6Cfg.RVZCMT;
    isa_map[IsaBitRvzcmp]        = CVA6Cfg.RVZCMP;
    isa_map[IsaBitRvzicond]      = CVA6Cfg.RVZiCond;
    isa_map[IsaBitRvzicntr]      = CVA6Cfg.RVZicntr;
    isa_map[IsaBitRvzihpm]       = CVA6Cfg.RVZihpm;
    isa_map[IsaBitRvzilsd]       = CVA6Cfg.RVZilsd;
    isa_map[IsaBitXf16]          = CVA6Cfg.XF16;
    isa_map[IsaBitXf16alt]       = CVA6Cfg.XF16ALT;
    isa_map[IsaBitXf8]           = CVA6Cfg.XF8;
    isa_map[IsaBitXfvec]         = CVA6Cfg.XFVec;
    isa_map[IsaBitCvxifEn]       = CVA6Cfg.CvxifEn;
    isa_map[IsaBitMmuPresent]    = CVA6Cfg.MmuPresent;
    isa_map[IsaBitSuperscalarEn] = CVA6Cfg.SuperscalarEn;
  end

  always_comb begin
    entry[CFG_XLEN]               = CVA6Cfg.XLEN;
    entry[CFG_VLEN]               = CVA6Cfg.VLEN;
    entry[CFG_PLEN]               = CVA6Cfg.PLEN;
    entry[CFG_GPLEN]              = CVA6Cfg.GPLEN;
    entry[CFG_ISA]                = isa_map;
    entry[CFG_NR_COMMIT_PORTS]    = CVA6Cfg.NrCommitPorts;
    entry[CFG_NR_ISSUE_PORTS]     = CVA6Cfg.NrIssuePorts;
    entry[CFG_NR_SB_ENTRIES]      = CVA6Cfg.NR_SB_ENTRIES;
    entry[CFG_NR_WB_PORTS]        = CVA6Cfg.NrWbPorts;
    entry[CFG_NR_RGPR_PORTS]      = CVA6Cfg.NrRgprPorts;
    entry[CFG_FLEN]               = CVA6Cfg.FLen;
    entry[CFG_ICACHE_SET_ASSOC]   = CVA6Cfg.ICACHE_SET_ASSOC;
    entry[CFG_ICACHE_INDEX_WIDTH] = CVA6Cfg.ICACHE_INDEX_WIDTH;
    entry[CFG_ICACHE_LINE_WIDTH]  = CVA6Cfg.ICACHE_LINE_WIDTH;
    entry[CFG_DCACHE_SET_ASSOC]   = CVA6Cfg.DCACHE_SET_ASSOC;
    entry[CFG_DCACHE_INDEX_WIDTH] = CVA6Cfg.DCACHE_INDEX_WIDTH;
    entry[CFG_DCACHE_LINE_WIDTH]  = CVA6Cfg.DCACHE_LINE_WIDTH;
    entry[CFG_DCACHE_TYPE]        = 32'(CVA6Cfg.DCacheType);
    entry[CFG_INSTR_TLB_ENTRIES]  = CVA6Cfg.InstrTlbEntries;
    entry[CFG_DATA_TLB_ENTRIES]   = CVA6Cfg.DataTlbEntries;
    entry[CFG_NR_PMP_ENTRIES]     = CVA6Cfg.NrPMPEntries;
    entry[CFG_BTB_ENTRIES]        = CVA6Cfg.BTBEntries;
    entry[CFG_BHT_ENTRIES]        = CVA6Cfg.BHTEntries;
    entry[CFG_RAS_DEPTH]          = CVA6Cfg.RASDepth;
    entry[CFG_FETCH_WIDTH]        = CVA6Cfg.FETCH_WIDTH;
    entry[CFG_AXI_DATA_WIDTH]     = CVA6Cfg.AxiDataWidth;
  end

  // The range check guards the 5-bit array select; out-of-range reads are 0.
  assign oor_a  = (idx_a >= 6'(CfgNumEntries));
  assign word_a = oor_a ? '0 : entry[idx_a[4:0]];
  assign word_b = (idx_b >= 6'(CfgNumEntries)) ? '0 : entry[idx_b[4:0]];

endmodule

// File: rtl/cva6_cfg_reader.sv
// ----------------------------------------------------------------------------
// cva6_cfg_reader
//
// Publishes the elaborated core configuration as a table of 32-bit words to a
// debug/boot agent through two independent paths:
//   - random read: request sampled each cycle, response exactly one cycle
//     later, no backpressure;
//   - stream dump: header {Magic, NumEntries}, then every table word, framed
//     with valid/ready and a last flag.
//
// Optional feature macro: CVA6_CFG_READER_CSUM_EN
//   defined   : a trailing checksum word (XOR of header and body) ends the frame
//   undefined : the frame ends on the last table word
//
// Ports:
//   clk_i         in  1   clock
//   rst_i         in  1   synchronous active-high reset
//   rd_req_i      in  1   random-read request
//   rd_addr_i     in  6   table index
//   rd_valid_o    out 1   read response valid
//   rd_data_o     out 32  read response data
//   rd_err_o      out 1   index out of range
//   dump_start_i  in  1   start stream dump (ignored while busy)
//   dump_abort_i  in  1   abort dump in progress
//   dump_valid_o  out 1   stream word valid
//   dump_ready_i  in  1   sink ready
//   dump_data_o   out 32  stream word
//   dump_last_o   out 1   final word of frame
//   busy_o        out 1   dump in progress
// ----------------------------------------------------------------------------
module cva6_cfg_reader
  import cfg_reader_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg    = cva6_cfg_empty,
  parameter int unsigned NumEntries = CfgNumEntries,
  parameter logic [15:0] Magic      = CfgMagic
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rd_req_i,
  input  logic [5:0]  rd_addr_i,
  output logic        rd_valid_o,
  output logic [31:0] rd_data_o,
  output logic        rd_err_o,
  input  logic        dump_start_i,
  input  logic        dump_abort_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [31:0] dump_data_o,
  output logic        dump_last_o,
  output logic        busy_o
);

  if (NumEntries != CfgNumEntries) begin : g_num_entries_check
    $error("cva6_cfg_reader: NumEntries must equal CfgNumEntries");
  end

  localparam logic [31:0] HdrWord = {Magic, 16'(NumEntries)};
  localparam logic [4:0]  LastIdx = 5'(NumEntries - 1);

  logic [31:0] rd_word;
  logic        rd_oor;
  logic [31:0] body_word;

  dump_state_e state_q, state_d;
  logic [4:0]  idx_q, idx_d;

`ifdef CVA6_CFG_READER_CSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  cva6_cfg_table #(
    .CVA6Cfg (CVA6Cfg)
  ) u_table (
    .idx_a  (rd_addr_i),
    .word_a (rd_word),
    .oor_a  (rd_oor),
    .idx_b  ({1'b0, idx_q}),
    .word_b (body_word)
  );

  // ---- random read: request -> response register (stage p1) ----
  logic        rd_vld_p1;
  logic        rd_err_p1;
  logic [31:0] rd_data_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_p1  <= 1'b0;
      rd_err_p1  <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      rd_vld_p1  <= rd_req_i;
      rd_err_p1  <= rd_req_i & rd_oor;
      rd_data_p1 <= rd_req_i ? rd_word : '0;
    end
  end

  assign rd_valid_o = rd_vld_p1;
  assign rd_err_o   = rd_err_p1;
  assign rd_data_o  = rd_data_p1;

  // ---- dump FSM: state register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef CVA6_CFG_READER_CSUM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // ---- dump FSM: next state ----
  // Abort is checked before the handshake so an aborted word never counts
  // as sent (index and checksum are left untouched).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef CVA6_CFG_READER_CSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      DUMP_IDLE: begin
        if (dump_start_i && !dump_abort_i) begin
          state_d = DUMP_HDR;
`ifdef CVA6_CFG_READER_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      DUMP_HDR: begin
        if (dump_abort_i) begin
          state_d = DUMP_IDLE;
        end else if (dump_ready_i) begin
          state_d = DUMP_BODY;
          idx_d   = '0;
`ifdef CVA6_CFG_READER_CSUM_EN
          csum_d  = csum_q ^ HdrWord;
`endif
        end
      end
      DUMP_BODY: begin
        if (dump_abort_i) begin
          state_d = DUMP_IDLE;
        end else if (dump_ready_i) begin
`ifdef CVA6_CFG_READER_CSUM_EN
          csum_d = csum_q ^ body_word;
`endif
          if (idx_q == LastIdx) begin
`ifdef CVA6_CFG_READER_CSUM_EN
            state_d = DUMP_CSUM;
`else
            state_d = DUMP_IDLE;
`endif
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
`ifdef CVA6_CFG_READER_CSUM_EN
      DUMP_CSUM: begin
        if (dump_abort_i || dump_ready_i) begin
          state_d = DUMP_IDLE;
        end
      end
`endif
      default: state_d = DUMP_IDLE;
    endcase
  end

  // ---- dump FSM: outputs ----
  // Outputs depend only on registered state, so they hold while stalled.
  always_comb begin
    dump_valid_o = 1'b0;
    busy_o       = 1'b0;
    dump_data_o  = '0;
    dump_last_o  = 1'b0;
    unique case (state_q)
      DUMP_HDR: begin
        dump_valid_o = 1'b1;
        busy_o       = 1'b1;
        dump_data_o  = HdrWord;
      end
      DUMP_BODY: begin
        dump_valid_o = 1'b1;
        busy_o       = 1'b1;
        dump_data_o  = body_word;
`ifndef CVA6_CFG_READER_CSUM_EN
        dump_last_o  = (idx_q == LastIdx);
`endif
      end
`ifdef CVA6_CFG_READER_CSUM_EN
      DUMP_CSUM: begin
        dump_valid_o = 1'b1;
        busy_o       = 1'b1;
        dump_data_o  = csum_q;
        dump_last_o  = 1'b1;
      end
`endif
      default: begin
        dump_valid_o = 1'b0;
      end
    endcase
  end

endmodule
